// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD sector channel among SD_IMAGES requesters; optional ISSUE abort under SD_ARB_TIMEOUT_EN.
// Grant to sd_rd/sd_wr: 1 cycle; sd_ack fall to req_done: 1 cycle; strobe/data routing is combinational.
module sd_req_arbiter #(
    parameter int          SD_IMAGES = 2,
    parameter logic [23:0] TIMEOUT   = 24'd12000000
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [SD_IMAGES-1:0]    req_rd,
    input  logic [SD_IMAGES-1:0]    req_wr,
    input  logic [32*SD_IMAGES-1:0] req_lba,
    input  logic [8*SD_IMAGES-1:0]  req_din,
    output logic [SD_IMAGES-1:0]    req_busy,
    output logic [SD_IMAGES-1:0]    req_done,
    output logic [SD_IMAGES-1:0]    req_err,
    output logic [SD_IMAGES-1:0]    req_dout_strobe,
    output logic [SD_IMAGES-1:0]    req_din_strobe,
    output logic [31:0]             sd_lba,
    output logic [SD_IMAGES-1:0]    sd_rd,
    output logic [SD_IMAGES-1:0]    sd_wr,
    input  logic                    sd_ack,
    input  logic                    sd_dout_strobe,
    input  logic                    sd_din_strobe,
    output logic [7:0]              sd_din
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        dir_q, dir_d;
    logic        mask_last_q, mask_last_d;
    logic [31:0] lba_q, lba_d;

    logic [SD_IMAGES-1:0] pend;
    logic                 found;
    logic [1:0]           win;
    logic                 win_wr;
    logic [31:0]          win_lba;
    logic [2:0]           idx;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Search starts at ptr and wraps; the requester just served is masked for one IDLE cycle.
    always_comb begin
        pend    = req_rd | req_wr;
        found   = 1'b0;
        win     = 2'd0;
        win_wr  = 1'b0;
        win_lba = 32'd0;
        idx     = 3'd0;
        for (int i = 0; i < SD_IMAGES; i++) begin
            if (mask_last_q && grant_q == 2'(i)) pend[i] = 1'b0;
        end
        for (int off = 0; off < SD_IMAGES; off++) begin
            idx = 3'(ptr_q) + 3'(off);
            if (idx >= 3'(SD_IMAGES)) idx = idx - 3'(SD_IMAGES);
            for (int i = 0; i < SD_IMAGES; i++) begin
                if (!found && idx == 3'(i) && pend[i]) begin
                    found   = 1'b1;
                    win     = 2'(i);
                    win_wr  = req_wr[i];
                    win_lba = req_lba[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        dir_d       = dir_q;
        mask_last_d = mask_last_q;
        lba_d       = lba_q;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                mask_last_d = 1'b0;
                if (found) begin
                    grant_d = win;
                    lba_d   = win_lba;
                    dir_d   = win_wr;
                    state_d = ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    state_d = XFER;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
            end
            XFER: begin
                if (!sd_ack) state_d = DONE;
            end
            DONE: begin
                ptr_d       = (grant_q == 2'(SD_IMAGES - 1)) ? 2'd0 : grant_q + 2'd1;
                mask_last_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'd0;
            ptr_q       <= 2'd0;
            dir_q       <= 1'b0;
            mask_last_q <= 1'b0;
            lba_q       <= 32'd0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            dir_q       <= dir_d;
            mask_last_q <= mask_last_d;
            lba_q       <= lba_d;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Outputs decode from registered state only, so reset clears them asynchronously.
    always_comb begin
        req_busy        = '0;
        req_done        = '0;
        req_err         = '0;
        req_dout_strobe = '0;
        req_din_strobe  = '0;
        sd_rd           = '0;
        sd_wr           = '0;
        sd_din          = 8'd0;
        sd_lba          = lba_q;
        for (int i = 0; i < SD_IMAGES; i++) begin
            if (grant_q == 2'(i)) begin
                req_busy[i] = (state_q != IDLE);
                req_done[i] = (state_q == DONE);
`ifdef SD_ARB_TIMEOUT_EN
                req_err[i]  = (state_q == DONE) && err_q;
`endif
                sd_rd[i]    = (state_q == ISSUE || state_q == XFER) && !dir_q;
                sd_wr[i]    = (state_q == ISSUE || state_q == XFER) && dir_q;
                if (state_q == XFER) begin
                    req_dout_strobe[i] = sd_dout_strobe;
                    req_din_strobe[i]  = sd_din_strobe;
                    sd_din             = req_din[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter with two requesters; define SD_ARB_TIMEOUT_EN to exercise the ISSUE abort.
module tb_sd_req_arbiter;

`ifdef SD_ARB_TIMEOUT_EN
    localparam logic [23:0] TO = 24'd16;
`else
    localparam logic [23:0] TO = 24'd12000000;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  req_rd, req_wr;
    logic [63:0] req_lba;
    logic [15:0] req_din;
    logic [1:0]  req_busy, req_done, req_err, req_dout_strobe, req_din_strobe;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_dout_strobe, sd_din_strobe;
    logic [7:0]  sd_din;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [1:0] rd; logic [1:0] wr; logic [31:0] lba; } grant_t;
    typedef struct { logic [1:0] done; logic [1:0] err; } done_t;
    grant_t exp_g[$];
    done_t  exp_d[$];

    sd_req_arbiter #(.SD_IMAGES(2), .TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_din(req_din),
        .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
        .req_dout_strobe(req_dout_strobe), .req_din_strobe(req_din_strobe),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_dout_strobe(sd_dout_strobe), .sd_din_strobe(sd_din_strobe), .sd_din(sd_din)
    );

    initial forever #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic push_g(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] lba);
        grant_t e;
        e.rd = rd; e.wr = wr; e.lba = lba;
        exp_g.push_back(e);
    endtask

    task automatic push_d(input logic [1:0] done, input logic [1:0] err);
        done_t e;
        e.done = done; e.err = err;
        exp_d.push_back(e);
    endtask

    task automatic monitor();
        logic [1:0] prev;
        grant_t     g;
        done_t      d;
        prev = 2'b00;
        forever begin
            tick();
            if (reset) begin
                prev = 2'b00;
                continue;
            end
            if ((sd_rd | sd_wr) != 2'b00 && prev == 2'b00) begin
                if (exp_g.size() == 0) fail_now("unexpected_grant");
                else begin
                    g = exp_g.pop_front();
                    chk("grant_sd_rd", sd_rd, g.rd);
                    chk("grant_sd_wr", sd_wr, g.wr);
                    chk("grant_sd_lba", sd_lba, g.lba);
                end
            end
            prev = sd_rd | sd_wr;
            if (req_done != 2'b00) begin
                if (exp_d.size() == 0) fail_now("unexpected_done");
                else begin
                    d = exp_d.pop_front();
                    chk("req_done", req_done, d.done);
                    chk("req_err", req_err, d.err);
                end
            end
        end
    endtask

    // Plays the user I/O side for one grant, then releases the requester two cycles after its done.
    task automatic serve(input int n, input logic [7:0] exp_din);
        int g, w;
        bit rd;
        int dc[2], ic[2];
        w = 0;
        while ((sd_rd | sd_wr) == 2'b00 && w < 50) begin
            tick();
            w++;
        end
        if ((sd_rd | sd_wr) == 2'b00) begin
            fail_now("grant_wait");
            return;
        end
        g  = (sd_rd[1] | sd_wr[1]) ? 1 : 0;
        rd = (sd_rd != 2'b00);
        chk("din_in_issue", sd_din, 8'h00);
        tick();
        sd_ack = 1'b1;
        tick();
        dc = '{0, 0};
        ic = '{0, 0};
        for (int i = 0; i < n; i++) begin
            if (rd) sd_dout_strobe = 1'b1;
            else    sd_din_strobe  = 1'b1;
            #1;
            dc[0] += int'(req_dout_strobe[0]);
            dc[1] += int'(req_dout_strobe[1]);
            ic[0] += int'(req_din_strobe[0]);
            ic[1] += int'(req_din_strobe[1]);
            if (i == 0) chk("din_in_xfer", sd_din, exp_din);
            tick();
        end
        sd_dout_strobe = 1'b0;
        sd_din_strobe  = 1'b0;
        sd_ack         = 1'b0;
        tick();
        w = 0;
        while (req_done[g] == 1'b0 && w < 10) begin
            tick();
            w++;
        end
        chk("done_latency", w, 0);
        chk("dout_strobe_granted", dc[g], rd ? n : 0);
        chk("dout_strobe_other", dc[1-g], 0);
        chk("din_strobe_granted", ic[g], rd ? 0 : n);
        chk("din_strobe_other", ic[1-g], 0);
        tick();
        chk("done_one_cycle", req_done, 2'b00);
        tick();
        req_rd[g] = 1'b0;
        req_wr[g] = 1'b0;
    endtask

    task automatic run();
        int cnt;
        reset = 1'b1; req_rd = 2'b00; req_wr = 2'b00; req_lba = 64'd0;
        req_din = 16'hA53C; sd_ack = 1'b0; sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
        tick(); tick();
        chk("rst_outputs", {req_busy, req_done, req_err, req_dout_strobe, req_din_strobe, sd_rd, sd_wr, sd_din}, 64'd0);
        chk("rst_lba", sd_lba, 32'd0);
        reset = 1'b0;
        tick();

        // single read on requester 0, 512 bytes; held one extra cycle to probe the mask
        req_lba = 64'h0000_5678_0000_1234;
        push_g(2'b01, 2'b00, 32'h1234); push_d(2'b01, 2'b00);
        req_rd = 2'b01;
        tick();
        chk("rd_latency", sd_rd, 2'b01);
        chk("busy_issue", req_busy, 2'b01);
        chk("lba_latched", sd_lba, 32'h1234);
        req_lba[31:0] = 32'hDEADBEEF;
        tick();
        chk("lba_ignored_after_grant", sd_lba, 32'h1234);
        serve(512, 8'h3C);
        repeat (3) tick();
        chk("mask_no_regrant", sd_rd | sd_wr, 2'b00);

        // contention with ptr=1: order 1 then 0
        req_lba = {32'h0000_0B0B, 32'h0000_0A0A};
        push_g(2'b10, 2'b00, 32'h0B0B); push_d(2'b10, 2'b00);
        push_g(2'b01, 2'b00, 32'h0A0A); push_d(2'b01, 2'b00);
        req_rd = 2'b11;
        serve(4, 8'hA5);
        serve(4, 8'h3C);

        // write routing on requester 1
        push_g(2'b00, 2'b10, 32'h0B0B); push_d(2'b10, 2'b00);
        req_wr = 2'b10;
        serve(8, 8'hA5);
        chk("din_idle", sd_din, 8'h00);

        // contention with ptr=0: order 0 then 1
        req_lba = {32'h0000_0D0D, 32'h0000_0C0C};
        push_g(2'b01, 2'b00, 32'h0C0C); push_d(2'b01, 2'b00);
        push_g(2'b10, 2'b00, 32'h0D0D); push_d(2'b10, 2'b00);
        req_rd = 2'b11;
        serve(3, 8'h3C);
        serve(3, 8'hA5);

        // read and write together on requester 0: write wins
        push_g(2'b00, 2'b01, 32'h0C0C); push_d(2'b01, 2'b00);
        req_rd = 2'b01; req_wr = 2'b01;
        tick();
        chk("rw_sd_wr", sd_wr, 2'b01);
        chk("rw_sd_rd", sd_rd, 2'b00);
        serve(2, 8'h3C);

        // reset in the middle of a 100-byte read
        push_g(2'b01, 2'b00, 32'h0C0C);
        req_rd = 2'b01;
        tick();
        sd_ack = 1'b1;
        tick();
        sd_dout_strobe = 1'b1;
        repeat (100) tick();
        chk("pre_reset_strobe", req_dout_strobe, 2'b01);
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {req_busy, req_done, req_err, req_dout_strobe, req_din_strobe, sd_rd, sd_wr, sd_din}, 64'd0);
        chk("async_reset_lba", sd_lba, 32'd0);
        req_rd = 2'b00; sd_ack = 1'b0; sd_dout_strobe = 1'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("idle_after_reset", {req_busy, sd_rd, sd_wr}, 6'd0);
        // ptr was 1 before reset; order 0,1 shows it returned to 0
        req_lba = {32'h0000_0F0F, 32'h0000_0E0E};
        push_g(2'b01, 2'b00, 32'h0E0E); push_d(2'b01, 2'b00);
        push_g(2'b10, 2'b00, 32'h0F0F); push_d(2'b10, 2'b00);
        req_rd = 2'b11;
        serve(2, 8'h3C);
        serve(2, 8'hA5);

        // request with no acknowledge
        push_g(2'b01, 2'b00, 32'h0E0E);
        req_rd = 2'b01;
`ifdef SD_ARB_TIMEOUT_EN
        push_d(2'b01, 2'b01);
        tick();
        cnt = 0;
        while (sd_rd != 2'b00 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("timeout_issue_cycles", cnt, 16);
        chk("timeout_done", req_done, 2'b01);
        chk("timeout_err", req_err, 2'b01);
        req_rd = 2'b00;
        repeat (3) tick();
`else
        cnt = 0;
        repeat (1000) begin
            tick();
            cnt++;
        end
        chk("no_timeout_sd_rd", sd_rd, 2'b01);
        chk("no_timeout_busy", req_busy, 2'b01);
        reset = 1'b1;
        req_rd = 2'b00;
        tick();
        reset = 1'b0;
        tick();
`endif
        chk("grants_outstanding", exp_g.size(), 0);
        chk("dones_outstanding", exp_d.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            run();
            begin
                #500000;
                fail_now("global_timeout");
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
